// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the shift-add multiplier scheduler:
// FSM state encoding, default operand width and requester-ID type.
package mul_sched_pkg;

  localparam int unsigned OpWDefault = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef logic req_id_t;

  function automatic logic [1:0] id_to_onehot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Shift-add multiplier datapath: operand magnitude capture, accumulator,
// operand shifts, step counter and final sign fix of the result.
module mul_shift_add_core import mul_sched_pkg::*; #(
  parameter int unsigned OP_W = OpWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic              sign_i,
  output logic              last_o,
  output logic [2*OP_W-1:0] result_o
);

  localparam int unsigned PW   = 2 * OP_W;
  localparam int unsigned CntW = $clog2(OP_W + 1);

  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic [OP_W-1:0] a_mag, b_mag;

  always_comb begin
    // The most negative value maps onto itself, which read unsigned is its magnitude.
    a_mag    = (sign_i && a_i[OP_W-1]) ? -a_i : a_i;
    b_mag    = (sign_i && b_i[OP_W-1]) ? -b_i : b_i;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    if (load_i) begin
      mcand_d  = {{OP_W{1'b0}}, a_mag};
      mplier_d = {{OP_W{1'b0}}, b_mag};
      acc_d    = '0;
      cnt_d    = CntW'(OP_W);
      neg_d    = sign_i & (a_i[OP_W-1] ^ b_i[OP_W-1]);
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mplier_d = mplier_q >> 1;
      mcand_d  = mcand_q << 1;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  // Result includes the step being taken this cycle so the scheduler can register it directly.
  assign result_o = neg_q ? -acc_d : acc_d;
  assign last_o   = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Two-requester round-robin scheduler around a shared shift-add multiplier.
// Define MUL_SCHED_STATS_EN to add per-requester completed-operation counters.
module mul_scheduler import mul_sched_pkg::*; #(
  parameter int unsigned OP_W = OpWDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [OP_W-1:0]   a0_i,
  input  logic [OP_W-1:0]   b0_i,
  input  logic              sign0_i,
  input  logic [OP_W-1:0]   a1_i,
  input  logic [OP_W-1:0]   b1_i,
  input  logic              sign1_i,
  output logic [1:0]        ack_o,
  output logic [1:0]        done_o,
  output logic [2*OP_W-1:0] product_o,
  output logic              busy_o
`ifdef MUL_SCHED_STATS_EN
  ,
  output logic [7:0]        ops0_o,
  output logic [7:0]        ops1_o
`endif
);

  state_e            state_q, state_d;
  req_id_t           last_q, last_d;
  req_id_t           win_q, win_d;
  req_id_t           gnt;
  logic [1:0]        ack_q, ack_d;
  logic [2*OP_W-1:0] product_q, product_d;
  logic [2*OP_W-1:0] core_result;
  logic              core_load, core_step, core_last;
  logic [OP_W-1:0]   a_sel, b_sel;
  logic              sign_sel;

  always_comb begin
    // On a tie the requester not granted last wins.
    gnt       = (req_i == 2'b11) ? ~last_q : req_i[1];
    a_sel     = gnt ? a1_i : a0_i;
    b_sel     = gnt ? b1_i : b0_i;
    sign_sel  = gnt ? sign1_i : sign0_i;
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    ack_d     = 2'b00;
    product_d = product_q;
    core_load = 1'b0;
    core_step = 1'b0;
    case (state_q)
      StIdle: begin
        if (|req_i) begin
          core_load = 1'b1;
          win_d     = gnt;
          last_d    = gnt;
          ack_d     = id_to_onehot(gnt);
          state_d   = StRun;
        end
      end
      StRun: begin
        core_step = 1'b1;
        if (core_last) begin
          product_d = core_result;
          state_d   = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      ack_q     <= 2'b00;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      ack_q     <= ack_d;
      product_q <= product_d;
    end
  end

  mul_shift_add_core #(
    .OP_W(OP_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .load_i  (core_load),
    .step_i  (core_step),
    .a_i     (a_sel),
    .b_i     (b_sel),
    .sign_i  (sign_sel),
    .last_o  (core_last),
    .result_o(core_result)
  );

  assign ack_o     = ack_q;
  assign done_o    = (state_q == StDone) ? id_to_onehot(win_q) : 2'b00;
  assign product_o = product_q;
  assign busy_o    = (state_q != StIdle);

`ifdef MUL_SCHED_STATS_EN
  logic [7:0] ops0_q, ops0_d, ops1_q, ops1_d;

  always_comb begin
    ops0_d = ops0_q;
    ops1_d = ops1_q;
    if (done_o[0]) ops0_d = ops0_q + 8'd1;
    if (done_o[1]) ops1_d = ops1_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops0_q <= 8'd0;
      ops1_q <= 8'd0;
    end else begin
      ops0_q <= ops0_d;
      ops1_q <= ops1_d;
    end
  end

  assign ops0_o = ops0_q;
  assign ops1_o = ops1_q;
`endif

endmodule

// File: tb/tb_mul_scheduler.sv
// Self-checking bench for mul_scheduler: directed vector table, multi-cycle
// corner sequences and randomized operations against an arithmetic model.
module tb_mul_scheduler;

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req_i = 2'b00;
  logic [W-1:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic          s0 = 1'b0, s1 = 1'b0;
  logic [1:0]    ack, done;
  logic [PW-1:0] prod;
  logic          busy;
`ifdef MUL_SCHED_STATS_EN
  logic [7:0]    ops0, ops1;
`endif

  int errors = 0;
  int checks = 0;
  int last_gnt = 1;

  always #5 clk = ~clk;

  mul_scheduler #(
    .OP_W(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .a0_i     (a0),
    .b0_i     (b0),
    .sign0_i  (s0),
    .a1_i     (a1),
    .b1_i     (b1),
    .sign1_i  (s1),
    .ack_o    (ack),
    .done_o   (done),
    .product_o(prod),
    .busy_o   (busy)
`ifdef MUL_SCHED_STATS_EN
    ,
    .ops0_o   (ops0),
    .ops1_o   (ops1)
`endif
  );

  typedef struct {
    logic [1:0]    req;
    logic [W-1:0]  a0, b0;
    logic          s0;
    logic [W-1:0]  a1, b1;
    logic          s1;
    logic [1:0]    exp_ack;
    logic [PW-1:0] exp_prod;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    int ia, ib, p;
    ia = int'(a);
    ib = int'(b);
    if (s && a[W-1]) ia = ia - (1 << W);
    if (s && b[W-1]) ib = ib - (1 << W);
    p = ia * ib;
    return p[PW-1:0];
  endfunction

  function automatic logic [1:0] oh(input int w);
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  // No two ack or done bits may ever be high together.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ($countones(ack) > 1 || $countones(done) > 1) begin
        errors++;
        $display("FAIL onehot: ack=%b done=%b", ack, done);
      end
    end
  end

  // Starts and ends on a negedge with the DUT idle.
  task automatic run_op(input string name, input logic [1:0] r,
                        input logic [W-1:0] xa0, input logic [W-1:0] xb0, input logic xs0,
                        input logic [W-1:0] xa1, input logic [W-1:0] xb1, input logic xs1,
                        input logic [1:0] exp_ack, input logic [PW-1:0] exp_p,
                        input bit scramble);
    int n;
    int m;
    req_i = r; a0 = xa0; b0 = xb0; s0 = xs0; a1 = xa1; b1 = xb1; s1 = xs1;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 2'b00 && n < 20);
    check({name, " ack latency"}, n, 1);
    check({name, " ack"}, ack, exp_ack);
    last_gnt = exp_ack[1] ? 1 : 0;
    m = 0;
    do begin
      if (scramble) begin
        req_i = 2'($urandom_range(0, 3));
        a0 = W'($urandom); b0 = W'($urandom); s0 = 1'($urandom);
        a1 = W'($urandom); b1 = W'($urandom); s1 = 1'($urandom);
      end else begin
        req_i = 2'b00;
      end
      @(negedge clk); m++;
    end while (done == 2'b00 && m < 20);
    req_i = 2'b00;
    check({name, " done latency"}, m, W);
    check({name, " done"}, done, exp_ack);
    check({name, " product"}, prod, exp_p);
    @(negedge clk);
    check({name, " idle busy"}, busy, 0);
    check({name, " product hold"}, prod, exp_p);
  endtask

  initial begin : main
    int n;
    int w;
    int acks;
    int prev;
    int idle_run;
    int exp_w;
    int done_seen;
    logic [1:0] r;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    logic rs0, rs1;
    logic [PW-1:0] ep;

    vecs[0] = '{2'b01, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 2'b01, 8'hE1};
    vecs[1] = '{2'b10, 4'h0, 4'h0, 1'b0, 4'h8, 4'h8, 1'b1, 2'b10, 8'h40};
    vecs[2] = '{2'b10, 4'h0, 4'h0, 1'b0, 4'h8, 4'h8, 1'b0, 2'b10, 8'h40};
    vecs[3] = '{2'b01, 4'h8, 4'h1, 1'b1, 4'h0, 4'h0, 1'b0, 2'b01, 8'hF8};
    vecs[4] = '{2'b01, 4'hD, 4'h5, 1'b1, 4'h0, 4'h0, 1'b0, 2'b01, 8'hF1};
    vecs[5] = '{2'b11, 4'h7, 4'h3, 1'b0, 4'hF, 4'hF, 1'b1, 2'b10, 8'h01};
    vecs[6] = '{2'b11, 4'h7, 4'h3, 1'b0, 4'hF, 4'hF, 1'b1, 2'b01, 8'h15};
    vecs[7] = '{2'b10, 4'h0, 4'h0, 1'b0, 4'h0, 4'h9, 1'b1, 2'b10, 8'h00};
    vecs[8] = '{2'b01, 4'hF, 4'h7, 1'b1, 4'h0, 4'h0, 1'b0, 2'b01, 8'hF9};
    vecs[9] = '{2'b01, 4'h7, 4'h8, 1'b1, 4'h0, 4'h0, 1'b0, 2'b01, 8'hC8};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset ack", ack, 0);
    check("reset done", done, 0);
    check("reset busy", busy, 0);
    check("reset product", prod, 0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].s0,
             vecs[i].a1, vecs[i].b1, vecs[i].s1, vecs[i].exp_ack, vecs[i].exp_prod, 1'b0);
    end

    // Reset two cycles after ack aborts the operation
    req_i = 2'b01; a0 = 4'h5; b0 = 4'h5; s0 = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (ack == 2'b00 && n < 20);
    check("abort ack", ack, 2'b01);
    req_i = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort product", prod, 0);
    check("abort done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done != 2'b00) done_seen++;
    end
    check("abort no done", done_seen, 0);
    last_gnt = 1;
    run_op("post-reset tie", 2'b11, 4'h3, 4'h4, 1'b0, 4'h5, 4'h6, 1'b0, 2'b01, 8'h0C, 1'b0);

    // Held tie: grants alternate with period OP_W+2 and a single idle cycle
    req_i = 2'b11; a0 = 4'h2; b0 = 4'h3; s0 = 1'b0; a1 = 4'h4; b1 = 4'h5; s1 = 1'b0;
    acks = 0; prev = -1; idle_run = 0; exp_w = 1 - last_gnt;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (!busy) idle_run++;
      if (ack != 2'b00) begin
        check("arb ack", ack, oh(exp_w));
        if (prev >= 0) begin
          check("arb spacing", c - prev, W + 2);
          check("arb idle gap", idle_run, 1);
        end
        idle_run = 0; prev = c; last_gnt = exp_w; exp_w = 1 - exp_w; acks++;
        if (acks == 4) req_i = 2'b00;
      end
    end
    check("arb ack count", acks, 4);
    n = 0;
    while (done == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check("arb last product", prod, (last_gnt == 1) ? 8'd20 : 8'd6);
    @(negedge clk);

    // Randomized operations with mid-operation input changes
    for (int i = 0; i < 40; i++) begin
      r   = 2'($urandom_range(1, 3));
      ra0 = W'($urandom); rb0 = W'($urandom); rs0 = 1'($urandom);
      ra1 = W'($urandom); rb1 = W'($urandom); rs1 = 1'($urandom);
      w   = (r == 2'b11) ? (1 - last_gnt) : (r == 2'b10 ? 1 : 0);
      ep  = (w == 1) ? ref_mul(ra1, rb1, rs1) : ref_mul(ra0, rb0, rs0);
      run_op($sformatf("rand%0d", i), r, ra0, rb0, rs0, ra1, rb1, rs1, oh(w), ep, 1'b1);
    end

`ifdef MUL_SCHED_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_gnt = 1;
    check("stats reset ops0", ops0, 0);
    check("stats reset ops1", ops1, 0);
    run_op("stats r1", 2'b10, 4'h0, 4'h0, 1'b0, 4'h2, 4'h2, 1'b0, 2'b10, 8'h04, 1'b0);
    for (int i = 0; i < 256; i++) begin
      ra0 = W'($urandom); rb0 = W'($urandom);
      run_op("stats r0", 2'b01, ra0, rb0, 1'b0, 4'h0, 4'h0, 1'b0, 2'b01,
             ref_mul(ra0, rb0, 1'b0), 1'b0);
      if (i == 0) check("stats ops0 first", ops0, 1);
    end
    check("stats ops0 wrap", ops0, 0);
    check("stats ops1 kept", ops1, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
